// File: rtl/video_multi_sprite_core.sv
// Multi-sprite overlay stage: each sprite has a private RAM that is read and chroma-keyed
// per pixel, the highest-priority opaque sprite is composited over the upstream pixel.
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif
`ifndef RGB_SIZE
`define RGB_SIZE 12
`endif

package vga_pkg;
    typedef struct packed {
        logic [`H_SIZE-1:0]     hc;
        logic [`V_SIZE-1:0]     vc;
        logic                   start;
        logic [`RGB_SIZE/3-1:0] r;
        logic [`RGB_SIZE/3-1:0] g;
        logic [`RGB_SIZE/3-1:0] b;
    } vga_frame_t;
endpackage

module video_multi_sprite_core
    import vga_pkg::*;
#(
    parameter int                   NUM_SPRITES  = 4,
    parameter int                   SPRITE_HSIZE = 32,
    parameter int                   SPRITE_VSIZE = 32,
    parameter int                   NUM_FRAMES   = 4,
    parameter logic [`RGB_SIZE-1:0] KEY_COLOR    = '0,
    parameter string                MEM_FILE     = "",
    localparam int FAW = $clog2(NUM_FRAMES),
    localparam int XW  = $clog2(SPRITE_HSIZE),
    localparam int YW  = $clog2(SPRITE_VSIZE),
    localparam int RAW = FAW + YW + XW,
    localparam int SW  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic                              bypass,
    input  logic                              source_vld,
    input  vga_frame_t                        source_frame,
    output logic                              sink_vld,
    output vga_frame_t                        sink_frame,
    input  logic [NUM_SPRITES*(`H_SIZE+1)-1:0] x0,
    input  logic [NUM_SPRITES*(`V_SIZE+1)-1:0] y0,
    input  logic [NUM_SPRITES-1:0]            spr_en,
    input  logic [NUM_SPRITES-1:0]            mirror_h,
    input  logic [NUM_SPRITES-1:0]            anim_en,
    input  logic [7:0]                        anim_period,
    output logic [NUM_SPRITES-1:0]            collision,
    input  logic                              collision_clr,
    input  logic                              sprite_ram_we,
    input  logic [SW-1:0]                     sprite_ram_sel,
    input  logic [RAW-1:0]                    sprite_ram_addr_w,
    input  logic [`RGB_SIZE-1:0]              sprite_ram_din
);
    localparam int HW    = `H_SIZE + 1;
    localparam int VW    = `V_SIZE + 1;
    localparam int FW    = (FAW > 0) ? FAW : 1;
    localparam int DEPTH = 1 << RAW;

    logic [NUM_SPRITES-1:0]                 in_region;
    logic [NUM_SPRITES-1:0]                 in_region_s1;
    logic [NUM_SPRITES-1:0]                 opaque;
    logic [NUM_SPRITES-1:0][`RGB_SIZE-1:0]  dout;
    logic [NUM_SPRITES-1:0][FW-1:0]         frame_idx;
    logic [7:0]                             tick;
    logic                                   source_vld_s1;
    vga_frame_t                             frame_s1;
    vga_frame_t                             out_frame;
    logic [`RGB_SIZE-1:0]                   win_color;
    logic                                   any_opaque;
    logic                                   multi_hit;
    logic                                   accept;

    assign accept = source_vld & ~stall;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        logic signed [HW-1:0] dx;
        logic signed [VW-1:0] dy;
        logic [XW-1:0]        xm;
        logic [RAW-1:0]       raddr;
        logic [`RGB_SIZE-1:0] rd_data;
        logic [`RGB_SIZE-1:0] mem [DEPTH];

        assign dx = $signed({1'b0, source_frame.hc}) - $signed(x0[i*HW +: HW]);
        assign dy = $signed({1'b0, source_frame.vc}) - $signed(y0[i*VW +: VW]);
        // Sizes are powers of two, so 0 <= d < SIZE is just "all bits above the index are zero".
        assign in_region[i] = spr_en[i] & (dx[HW-1:XW] == '0) & (dy[VW-1:YW] == '0);
        assign xm    = mirror_h[i] ? ~dx[XW-1:0] : dx[XW-1:0];
        assign raddr = RAW'({frame_idx[i], dy[YW-1:0], xm});

        always_ff @(posedge clk) begin
            if (sprite_ram_we && sprite_ram_sel == SW'(i))
                mem[sprite_ram_addr_w] <= sprite_ram_din;
            if (!stall)
                rd_data <= mem[raddr];
        end

        assign dout[i]   = rd_data;
        assign opaque[i] = in_region_s1[i] & (rd_data != KEY_COLOR);
    end

    assign multi_hit = |(opaque & (opaque - NUM_SPRITES'(1)));

    always_comb begin
        win_color  = '0;
        any_opaque = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_color  = dout[i];
                any_opaque = 1'b1;
            end
        end
        out_frame = frame_s1;
        if (!bypass && any_opaque)
            {out_frame.r, out_frame.g, out_frame.b} = win_color;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            source_vld_s1 <= 1'b0;
            sink_vld      <= 1'b0;
        end else if (!stall) begin
            source_vld_s1 <= source_vld;
            sink_vld      <= source_vld_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            in_region_s1 <= in_region;
            frame_s1     <= source_frame;
            sink_frame   <= out_frame;
        end
    end

    // A new hit in the same cycle as a clear must survive it.
    always_ff @(posedge clk) begin
        if (rst)
            collision <= '0;
        else if (!stall)
            collision <= (collision_clr ? '0 : collision) |
                         ((source_vld_s1 && multi_hit) ? opaque : '0);
    end

    // Frames only step on a start pixel, so a whole video frame shows one animation frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick      <= '0;
            frame_idx <= '0;
        end else if (accept && source_frame.start && anim_period != 8'd0) begin
            if (tick == anim_period - 8'd1) begin
                tick <= '0;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (anim_en[i])
                        frame_idx[i] <= (frame_idx[i] == FW'(NUM_FRAMES - 1)) ? '0
                                                                              : frame_idx[i] + FW'(1);
                end
            end else begin
                tick <= tick + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_multi_sprite_core.sv
// Randomized bench for video_multi_sprite_core with a pixel-level reference model and
// a few directed probes for latency, mirroring, priority, animation and reset.
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif
`ifndef RGB_SIZE
`define RGB_SIZE 12
`endif

module tb_video_multi_sprite_core;
    localparam int NS    = 4;
    localparam int HS    = 32;
    localparam int VS    = 32;
    localparam int NF    = 4;
    localparam int FPS   = HS * VS;
    localparam int DEPTH = NF * FPS;
    localparam int HW    = `H_SIZE + 1;
    localparam int VW    = `V_SIZE + 1;
    localparam int CW    = `RGB_SIZE / 3;
    localparam logic [11:0] UP = 12'h5C3;

    typedef struct packed {
        logic [`H_SIZE-1:0] hc;
        logic [`V_SIZE-1:0] vc;
        logic               start;
        logic [CW-1:0]      r;
        logic [CW-1:0]      g;
        logic [CW-1:0]      b;
    } pix_t;

    logic             clk = 1'b0, rst = 1'b1, stall = 1'b0, bypass = 1'b0;
    logic             source_vld = 1'b0, sink_vld, collision_clr = 1'b0;
    pix_t             source_frame = '0, sink_frame;
    logic [NS*HW-1:0] x0 = '0;
    logic [NS*VW-1:0] y0 = '0;
    logic [NS-1:0]    spr_en = '0, mirror_h = '0, anim_en = '0, collision;
    logic [7:0]       anim_period = 8'd0;
    logic             sprite_ram_we = 1'b0;
    logic [1:0]       sprite_ram_sel = '0;
    logic [11:0]      sprite_ram_addr_w = '0;
    logic [11:0]      sprite_ram_din = '0;

    video_multi_sprite_core dut (
        .clk(clk), .rst(rst), .stall(stall), .bypass(bypass),
        .source_vld(source_vld), .source_frame(source_frame),
        .sink_vld(sink_vld), .sink_frame(sink_frame),
        .x0(x0), .y0(y0), .spr_en(spr_en), .mirror_h(mirror_h),
        .anim_en(anim_en), .anim_period(anim_period),
        .collision(collision), .collision_clr(collision_clr),
        .sprite_ram_we(sprite_ram_we), .sprite_ram_sel(sprite_ram_sel),
        .sprite_ram_addr_w(sprite_ram_addr_w), .sprite_ram_din(sprite_ram_din)
    );

    always #5 clk = ~clk;

    // reference state
    logic [11:0]   mem_m [NS][DEPTH];
    int            x0m [NS], y0m [NS], frame_m [NS];
    int            tick_m = 0;
    logic [NS-1:0] coll_m = '0;
    pix_t          exp_q [$];
    int            n_tests = 0, n_fail = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int a(input int f, input int y, input int x);
        return f * FPS + y * HS + x;
    endfunction

    function automatic pix_t mkpix(input int hc, input int vc, input bit st, input logic [11:0] c);
        pix_t p;
        p.hc = `H_SIZE'(hc);
        p.vc = `V_SIZE'(vc);
        p.start = st;
        {p.r, p.g, p.b} = c;
        return p;
    endfunction

    // What the pixel should look like downstream, and which sprites are opaque on it.
    function automatic pix_t model_pix(input pix_t p, output logic [NS-1:0] opq);
        pix_t        o = p;
        int          dx, dy, x, win;
        logic [11:0] c;
        logic [11:0] wc = '0;
        win = -1;
        opq = '0;
        for (int s = 0; s < NS; s++) begin
            dx = int'(p.hc) - x0m[s];
            dy = int'(p.vc) - y0m[s];
            if (spr_en[s] && dx >= 0 && dx < HS && dy >= 0 && dy < VS) begin
                x = mirror_h[s] ? HS - 1 - dx : dx;
                c = mem_m[s][a(frame_m[s], dy, x)];
                if (c != 12'h000) begin
                    opq[s] = 1'b1;
                    if (win < 0) begin
                        win = s;
                        wc  = c;
                    end
                end
            end
        end
        if (!bypass && win >= 0)
            {o.r, o.g, o.b} = wc;
        return o;
    endfunction

    task automatic apply_cfg();
        for (int s = 0; s < NS; s++) begin
            x0[s*HW +: HW] = HW'(x0m[s]);
            y0[s*VW +: VW] = VW'(y0m[s]);
        end
    endtask

    task automatic step(input bit vld, input pix_t p, input bit stl);
        logic [NS-1:0] opq;
        pix_t          e;
        @(posedge clk); #1;
        source_vld   = vld;
        source_frame = p;
        stall        = stl;
        if (vld && !stl) begin
            e = model_pix(p, opq);
            exp_q.push_back(e);
            if ($countones(opq) >= 2)
                coll_m |= opq;
            if (p.start && anim_period != 8'd0) begin
                if (tick_m == int'(anim_period) - 1) begin
                    tick_m = 0;
                    for (int s = 0; s < NS; s++)
                        if (anim_en[s]) frame_m[s] = (frame_m[s] + 1) % NF;
                end else begin
                    tick_m = (tick_m + 1) % 256;
                end
            end
        end
    endtask

    task automatic wr(input int s, input int addr, input logic [11:0] d);
        @(posedge clk); #1;
        sprite_ram_we     = 1'b1;
        sprite_ram_sel    = 2'(s);
        sprite_ram_addr_w = 12'(addr);
        sprite_ram_din    = d;
        mem_m[s][addr]    = d;
    endtask

    task automatic wr_done();
        @(posedge clk); #1;
        sprite_ram_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic clr_coll();
        @(posedge clk); #1; collision_clr = 1'b1;
        @(posedge clk); #1; collision_clr = 1'b0;
        coll_m = '0;
    endtask

    // Single isolated pixel: must come out exactly two cycles later with the given colour.
    task automatic probe(input string tag, input int hc, input int vc, input bit st,
                         input logic [11:0] exp_c);
        int n = 0;
        step(1'b1, mkpix(hc, vc, st, UP), 1'b0);
        do begin
            step(1'b0, '0, 1'b0);
            @(negedge clk);
            n++;
        end while (!sink_vld && n < 8);
        chk({tag, "_lat"}, 64'(n), 2);
        chk(tag, 64'({sink_frame.r, sink_frame.g, sink_frame.b}), 64'(exp_c));
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; source_vld = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        tick_m = 0;
        coll_m = '0;
        for (int s = 0; s < NS; s++) frame_m[s] = 0;
        @(negedge clk);
        chk("rst_vld", 64'(sink_vld), 0);
        chk("rst_coll", 64'(collision), 0);
    endtask

    // Output checker: every consumed output pops one expectation; stalled outputs must hold.
    pix_t prev_out;
    bit   prev_vld = 1'b0, prev_hold = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold && prev_vld)
                chk("hold", {sink_vld, sink_frame}, {1'b1, prev_out});
            if (sink_vld && !stall) begin
                if (exp_q.size() == 0) chk("spurious", 64'(sink_vld), 0);
                else                   chk("pix", 64'(sink_frame), 64'(exp_q.pop_front()));
            end
            prev_hold = stall && !rst;
            prev_vld  = sink_vld;
            prev_out  = sink_frame;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < NS; s++) begin
            x0m[s] = 0; y0m[s] = 0; frame_m[s] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", 64'(sink_vld), 0);
        chk("rst_coll", 64'(collision), 0);
        mon_en = 1'b1;

        for (int s = 0; s < NS; s++)
            for (int i = 0; i < DEPTH; i++)
                wr(s, i, ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095)));
        wr_done();

        // single sprite region and borders
        x0m[0] = 100; y0m[0] = 50; apply_cfg(); spr_en = 4'b0001;
        for (int i = 0; i < FPS; i++) wr(0, i, 12'hABC);
        wr_done();
        probe("in_tl", 100, 50, 1'b0, 12'hABC);
        probe("in_br", 131, 81, 1'b0, 12'hABC);
        probe("out_l", 99, 50, 1'b0, UP);
        probe("out_r", 132, 81, 1'b0, UP);
        probe("out_b", 100, 82, 1'b0, UP);
        bypass = 1'b1;
        probe("bypass", 110, 60, 1'b0, UP);
        bypass = 1'b0;
        for (int i = 0; i < 200; i++)
            step(1'b1, mkpix($urandom_range(90, 140), $urandom_range(40, 90), 1'b0,
                             12'($urandom)), 1'b0);
        drain();

        // mirror
        x0m[0] = 0; y0m[0] = 0; apply_cfg(); mirror_h = 4'b0001;
        wr(0, a(0, 0, 0), 12'h111); wr(0, a(0, 0, 31), 12'h222); wr_done();
        probe("mir0", 0, 0, 1'b0, 12'h222);
        probe("mir31", 31, 0, 1'b0, 12'h111);

        // negative origin
        mirror_h = '0; x0m[0] = -8; y0m[0] = -4; apply_cfg();
        wr(0, a(0, 4, 8), 12'h5A5); wr_done();
        probe("neg_org", 0, 0, 1'b0, 12'h5A5);
        probe("neg_edge", 23, 0, 1'b0, 12'hABC);
        probe("neg_out", 24, 0, 1'b0, UP);

        // priority and collision
        x0m[0] = 10; y0m[0] = 10; x0m[1] = 10; y0m[1] = 10; apply_cfg(); spr_en = 4'b0011;
        wr(0, a(0, 0, 0), 12'h0A0); wr(1, a(0, 0, 0), 12'h0B0); wr_done();
        probe("prio", 10, 10, 1'b0, 12'h0A0);
        chk("coll_set", 64'(collision), 64'h3);
        clr_coll();
        chk("coll_clr", 64'(collision), 0);
        wr(0, a(0, 0, 0), 12'h000); wr_done();
        probe("key", 10, 10, 1'b0, 12'h0B0);
        chk("coll_single", 64'(collision), 0);
        wr(0, a(0, 0, 1), 12'h0C0); wr(1, a(0, 0, 1), 12'h0D0); wr_done();
        probe("prio2", 11, 10, 1'b0, 12'h0C0);
        chk("coll_reset", 64'(collision), 64'h3);
        clr_coll();

        // animation
        spr_en = 4'b0001; x0m[0] = 200; y0m[0] = 200; apply_cfg();
        anim_en = 4'b0001; anim_period = 8'd2;
        for (int f = 0; f < NF; f++) wr(0, a(f, 0, 0), 12'(12'h100 * (f + 1)));
        wr_done();
        for (int k = 0; k < 9; k++)
            probe("anim", 200, 200, 1'b1, 12'(12'h100 * ((k / 2) % NF + 1)));
        anim_period = 8'd0;
        for (int k = 0; k < 3; k++) probe("frozen", 200, 200, 1'b1, 12'h100);
        anim_period = 8'd2;
        probe("anim_step", 200, 200, 1'b1, 12'h100);
        anim_en = '0;
        probe("anim_hold", 200, 200, 1'b1, 12'h200);
        probe("anim_hold2", 200, 200, 1'b1, 12'h200);

        // stall mid-line with continuous input
        for (int i = 0; i < 30; i++)
            step(1'b1, mkpix(195 + i, 200 + (i % 3), 1'b0, 12'($urandom)), i >= 10 && i < 15);
        drain();

        // randomized batches
        for (int b = 0; b < 20; b++) begin
            for (int s = 0; s < NS; s++) begin
                x0m[s] = $urandom_range(0, 76) - 16;
                y0m[s] = $urandom_range(0, 76) - 16;
            end
            apply_cfg();
            spr_en      = 4'($urandom);
            mirror_h    = 4'($urandom);
            anim_en     = 4'($urandom);
            anim_period = 8'($urandom_range(0, 3));
            bypass      = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 99) < 85,
                     mkpix($urandom_range(0, 110), $urandom_range(0, 110),
                           $urandom_range(0, 15) == 0, 12'($urandom)),
                     $urandom_range(0, 99) < 20);
            drain();
            chk("coll_rand", 64'(collision), 64'(coll_m));
            if ($urandom_range(0, 1) == 1) clr_coll();
        end

        // reset mid-line, then frames must be back at 0
        bypass = 1'b0;
        for (int i = 0; i < 10; i++)
            step(1'b1, mkpix($urandom_range(0, 110), $urandom_range(0, 110), 1'b0, 12'($urandom)),
                 1'b0);
        do_reset();
        spr_en = 4'b0001; mirror_h = '0; anim_en = '0;
        x0m[0] = 200; y0m[0] = 200; apply_cfg();
        probe("rst_frame", 200, 200, 1'b0, 12'h100);
        for (int i = 0; i < 50; i++)
            step(1'b1, mkpix($urandom_range(190, 240), $urandom_range(190, 240), 1'b0,
                             12'($urandom)), 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
